banco_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the `BancoRegistro` register bank. It shares the bank's single write port (`addrW`/`datW`/`RegWrite`) and read port A (`addrRa`/`datOutRa`) between two clients using a req/ack handshake. Each request is a single read or a single write. The block sits between the bank and its clients; read port B stays outside the arbiter and connects directly to whoever needs it.

---
 rtl/banco_arbiter.sv | 140 ++++++++++++++
 tb/tb_banco_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/banco_arbiter.sv
// Two-client round-robin arbiter sharing the BancoRegistro write port and read port A.
// Each granted request runs IDLE -> ACCESS -> ACK; every output is registered.
module banco_arbiter #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned DATA_W   = 4,
    parameter bit          PROTECT0 = 1'b0
) (
    input  logic              clk1,
    input  logic              rst1,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dat0,
    input  logic [DATA_W-1:0] dat1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] datW,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] addrRa,
    input  logic [DATA_W-1:0] datOutRa
);

    typedef enum logic [1:0] {StIdle, StAccess, StAck} stateT;

    stateT             stateQ, stateD;
    logic              lastQ, lastD;
    logic              gntIdQ, gntIdD;
    logic              gntWeQ, gntWeD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic [DATA_W-1:0] datWD;
    logic [DATA_W-1:0] rdata0D, rdata1D;
    logic              regWriteD, ack0D, ack1D, busyD;

    logic              grantId;
    logic              grantWe;
    logic [ADDR_W-1:0] grantAddr;
    logic [DATA_W-1:0] grantDat;

    // On a tie the client not served last wins.
    always_comb begin
        if (req0 && req1) begin
            grantId = ~lastQ;
        end else begin
            grantId = req1;
        end
        grantWe   = grantId ? we1   : we0;
        grantAddr = grantId ? addr1 : addr0;
        grantDat  = grantId ? dat1  : dat0;
    end

    always_comb begin
        stateD    = stateQ;
        lastD     = lastQ;
        gntIdD    = gntIdQ;
        gntWeD    = gntWeQ;
        addrD     = addrQ;
        datWD     = datW;
        rdata0D   = rdata0;
        rdata1D   = rdata1;
        regWriteD = 1'b0;
        ack0D     = 1'b0;
        ack1D     = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (req0 || req1) begin
                    stateD    = StAccess;
                    lastD     = grantId;
                    gntIdD    = grantId;
                    gntWeD    = grantWe;
                    addrD     = grantAddr;
                    datWD     = grantDat;
                    regWriteD = grantWe && !(PROTECT0 && (grantAddr == '0));
                end
            end
            StAccess: begin
                stateD = StAck;
                if (!gntWeQ) begin
                    if (gntIdQ) begin
                        rdata1D = datOutRa;
                    end else begin
                        rdata0D = datOutRa;
                    end
                end
                ack0D = !gntIdQ;
                ack1D = gntIdQ;
            end
            StAck: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        busyD = (stateD != StIdle);
    end

    always_ff @(posedge clk1) begin
        if (!rst1) begin
            stateQ   <= StIdle;
            lastQ    <= 1'b1;
            gntIdQ   <= 1'b0;
            gntWeQ   <= 1'b0;
            addrQ    <= '0;
            datW     <= '0;
            rdata0   <= '0;
            rdata1   <= '0;
            RegWrite <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            stateQ   <= stateD;
            lastQ    <= lastD;
            gntIdQ   <= gntIdD;
            gntWeQ   <= gntWeD;
            addrQ    <= addrD;
            datW     <= datWD;
            rdata0   <= rdata0D;
            rdata1   <= rdata1D;
            RegWrite <= regWriteD;
            ack0     <= ack0D;
            ack1     <= ack1D;
            busy     <= busyD;
        end
    end

    // One captured address serves both bank ports.
    assign addrW  = addrQ;
    assign addrRa = addrQ;

endmodule

// File: tb/tb_banco_arbiter.sv
// Scoreboard bench for banco_arbiter: stimulus pushes expected acks, a negedge monitor
// pops and compares client id, ack cycle and both rdata values.
module tb_banco_arbiter;

    typedef struct {
        bit         id;
        int         cyc;
        logic [3:0] r0;
        logic [3:0] r1;
    } expT;

    expT sbA[$];
    expT sbB[$];
    int  nCmp = 0;
    int  nBad = 0;
    int  cyc  = 0;

    logic       clk1 = 1'b0;
    logic       rst1 = 1'b0;
    logic       req0, req1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [3:0] dat0, dat1;
    logic       ack0, ack1, busy, RegWrite;
    logic [3:0] rdata0, rdata1, datW, datOutRa;
    logic [2:0] addrW, addrRa;

    logic       pReq0, pWe0;
    logic [2:0] pAddr0;
    logic [3:0] pDat0;
    logic       pAck0, pAck1, pBusy, pRegWrite;
    logic [3:0] pRdata0, pRdata1, pDatW, pDatOutRa;
    logic [2:0] pAddrW, pAddrRa;

    logic [3:0] bank  [8] = '{default: 4'h0};
    logic [3:0] bankP [8] = '{0: 4'h7, default: 4'h0};

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    always @(posedge clk1) if (RegWrite) bank[addrW] <= datW;
    always @(posedge clk1) if (pRegWrite) bankP[pAddrW] <= pDatW;
    assign datOutRa  = bank[addrRa];
    assign pDatOutRa = bankP[pAddrRa];

    banco_arbiter #(.ADDR_W(3), .DATA_W(4), .PROTECT0(1'b0)) dut (
        .clk1(clk1), .rst1(rst1),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .dat0(dat0), .dat1(dat1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .addrW(addrW), .datW(datW), .RegWrite(RegWrite),
        .addrRa(addrRa), .datOutRa(datOutRa)
    );

    banco_arbiter #(.ADDR_W(3), .DATA_W(4), .PROTECT0(1'b1)) dutP (
        .clk1(clk1), .rst1(rst1),
        .req0(pReq0), .req1(1'b0), .we0(pWe0), .we1(1'b0),
        .addr0(pAddr0), .addr1(3'd0), .dat0(pDat0), .dat1(4'd0),
        .ack0(pAck0), .ack1(pAck1), .rdata0(pRdata0), .rdata1(pRdata1), .busy(pBusy),
        .addrW(pAddrW), .datW(pDatW), .RegWrite(pRegWrite),
        .addrRa(pAddrRa), .datOutRa(pDatOutRa)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        nCmp++;
        if (act !== req) begin
            nBad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pushExp(input bit inst, input bit id, input int c,
                           input logic [3:0] r0, input logic [3:0] r1);
        expT e;
        e.id  = id;
        e.cyc = c;
        e.r0  = r0;
        e.r1  = r1;
        if (inst) sbB.push_back(e);
        else      sbA.push_back(e);
    endtask

    task automatic popCheck(input bit inst, input bit id,
                            input logic [3:0] r0, input logic [3:0] r1);
        expT e;
        int  pending;
        pending = inst ? sbB.size() : sbA.size();
        cmp($sformatf("ack%0d_i%0d_expected", id, inst), 32'(pending > 0), 1);
        if (pending > 0) begin
            if (inst) e = sbB.pop_front();
            else      e = sbA.pop_front();
            cmp($sformatf("ack_id_i%0d", inst), 32'(id), 32'(e.id));
            cmp($sformatf("ack_cycle_i%0d", inst), cyc, e.cyc);
            cmp($sformatf("rdata0_i%0d", inst), 32'(r0), 32'(e.r0));
            cmp($sformatf("rdata1_i%0d", inst), 32'(r1), 32'(e.r1));
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk1) begin
        if (ack0)  popCheck(1'b0, 1'b0, rdata0, rdata1);
        if (ack1)  popCheck(1'b0, 1'b1, rdata0, rdata1);
        if (pAck0) popCheck(1'b1, 1'b0, pRdata0, pRdata1);
        if (pAck1) popCheck(1'b1, 1'b1, pRdata0, pRdata1);
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, "_ack0"}, 32'(ack0), 0);
        cmp({tag, "_ack1"}, 32'(ack1), 0);
        cmp({tag, "_busy"}, 32'(busy), 0);
        cmp({tag, "_RegWrite"}, 32'(RegWrite), 0);
        cmp({tag, "_addrW"}, 32'(addrW), 0);
        cmp({tag, "_addrRa"}, 32'(addrRa), 0);
        cmp({tag, "_datW"}, 32'(datW), 0);
        cmp({tag, "_rdata0"}, 32'(rdata0), 0);
        cmp({tag, "_rdata1"}, 32'(rdata1), 0);
    endtask

    task automatic protTxn(input logic w, input logic [2:0] a, input logic [3:0] d,
                           input logic expWr, input logic [3:0] expR0);
        pReq0  = 1'b1;
        pWe0   = w;
        pAddr0 = a;
        pDat0  = d;
        pushExp(1'b1, 1'b0, cyc + 2, expR0, 4'h0);
        tick();
        cmp("prot_RegWrite", 32'(pRegWrite), 32'(expWr));
        cmp("prot_busy", 32'(pBusy), 1);
        tick();
        pReq0 = 1'b0;
        tick();
    endtask

    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; dat0 = 0; dat1 = 0;
        pReq0 = 0; pWe0 = 0; pAddr0 = 0; pDat0 = 0;

        repeat (3) tick();
        checkReset("por");
        rst1 = 1'b1;
        tick();

        // Single write: addr 3 <= A
        req0 = 1; we0 = 1; addr0 = 3; dat0 = 4'hA;
        pushExp(1'b0, 1'b0, cyc + 2, 4'h0, 4'h0);
        tick();
        cmp("wr_RegWrite_n1", 32'(RegWrite), 1);
        cmp("wr_addrW", 32'(addrW), 3);
        cmp("wr_datW", 32'(datW), 4'hA);
        cmp("wr_busy_n1", 32'(busy), 1);
        tick();
        cmp("wr_busy_n2", 32'(busy), 1);
        cmp("wr_RegWrite_n2", 32'(RegWrite), 0);
        req0 = 0;
        tick();
        cmp("wr_busy_n3", 32'(busy), 0);
        cmp("wr_bank3", 32'(bank[3]), 4'hA);

        // Read back addr 3
        req0 = 1; we0 = 0; addr0 = 3;
        pushExp(1'b0, 1'b0, cyc + 2, 4'hA, 4'h0);
        tick();
        cmp("rd_addrRa", 32'(addrRa), 3);
        cmp("rd_RegWrite", 32'(RegWrite), 0);
        tick();
        req0 = 0;
        tick();

        // Fresh reset, then simultaneous writes: client 0 first
        rst1 = 0; tick(); rst1 = 1; tick();
        req0 = 1; we0 = 1; addr0 = 1; dat0 = 4'h5;
        req1 = 1; we1 = 1; addr1 = 2; dat1 = 4'h6;
        pushExp(1'b0, 1'b0, cyc + 2, 4'h0, 4'h0);
        pushExp(1'b0, 1'b1, cyc + 5, 4'h0, 4'h0);
        tick(); tick();
        req0 = 0;
        repeat (3) tick();
        req1 = 0;
        tick();
        cmp("tie_bank1", 32'(bank[1]), 4'h5);
        cmp("tie_bank2", 32'(bank[2]), 4'h6);

        // Sustained reads from both clients: strict alternation 0,1,0,1
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 2;
        pushExp(1'b0, 1'b0, cyc + 2, 4'h5, 4'h0);
        pushExp(1'b0, 1'b1, cyc + 5, 4'h5, 4'h6);
        pushExp(1'b0, 1'b0, cyc + 8, 4'h5, 4'h6);
        pushExp(1'b0, 1'b1, cyc + 11, 4'h5, 4'h6);
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k % 3 != 0) cmp($sformatf("rr_busy_k%0d", k), 32'(busy), 1);
        end
        req0 = 0; req1 = 0;
        repeat (2) tick();

        // Reset during ACCESS of a read: no ack, outputs back to reset values
        req0 = 1; we0 = 0; addr0 = 3;
        tick();
        cmp("abort_addrRa", 32'(addrRa), 3);
        rst1 = 0; req0 = 0;
        tick();
        checkReset("abort");
        rst1 = 1;
        tick();

        // Tie after reset: client 0 must win again
        req0 = 1; we0 = 0; addr0 = 2;
        req1 = 1; we1 = 0; addr1 = 1;
        pushExp(1'b0, 1'b0, cyc + 2, 4'h6, 4'h0);
        pushExp(1'b0, 1'b1, cyc + 5, 4'h6, 4'h5);
        tick(); tick();
        req0 = 0;
        repeat (3) tick();
        req1 = 0;
        tick();

        // Protected instance: write to addr 0 suppressed, other writes pass
        protTxn(1'b1, 3'd0, 4'hF, 1'b0, 4'h0);
        cmp("prot_bank0", 32'(bankP[0]), 4'h7);
        protTxn(1'b0, 3'd0, 4'h0, 1'b0, 4'h7);
        protTxn(1'b1, 3'd5, 4'h9, 1'b1, 4'h7);
        cmp("prot_bank5", 32'(bankP[5]), 4'h9);

        repeat (2) tick();
        cmp("sbA_drained", sbA.size(), 0);
        cmp("sbB_drained", sbB.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
